// File: rtl/recon_raster_out_pkg.sv
// Shared types and constants for the reconstructed-block raster output path.
package recon_raster_out_pkg;

    localparam int BLK_W      = 8;
    localparam int BLK_H      = 2;
    localparam int NUM_COMP   = 3;
    localparam int RECON_BITS = 14;
    localparam int PIX_BITS   = 12;
    localparam int BEAT_PIX   = 4;

    localparam int WORD_BITS = BEAT_PIX * NUM_COMP * PIX_BITS;
    localparam int BLK_BITS  = BLK_H * BLK_W * NUM_COMP * RECON_BITS;

    localparam logic [1:0] CSC_RGB   = 2'd0;
    localparam logic [1:0] CSC_YCOCG = 2'd1;
    localparam logic [1:0] CSC_YCBCR = 2'd2;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef struct packed {
        word_t data;
        logic  sol;
        logic  eol;
        logic  line;
        logic  last;
    } beat_t;

    function automatic logic [PIX_BITS-1:0] clip_pix(
        input logic signed [RECON_BITS-1:0] v,
        input logic        [12:0]           mx
    );
        logic signed [RECON_BITS-1:0] m;
        m = $signed({1'b0, mx});
        if (v[RECON_BITS-1]) return '0;
        if (v > m) return mx[PIX_BITS-1:0];
        return v[PIX_BITS-1:0];
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM with one-cycle registered read.
module sp_ram #(
    parameter int DW    = 144,
    parameter int DEPTH = 1280,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem[addr_i] <= wdata_i;
            else      rdata_o     <= mem[addr_i];
        end
    end

endmodule

// File: rtl/ycocg_to_rgb_clip.sv
// Per-pixel inverse YCoCg transform with clipping to [0, maxPoint].
module ycocg_to_rgb_clip
    import recon_raster_out_pkg::*;
(
    input  logic        [1:0]            csc_i,
    input  logic        [12:0]           max_point_i,
    input  logic signed [RECON_BITS-1:0] c0_i,
    input  logic signed [RECON_BITS-1:0] c1_i,
    input  logic signed [RECON_BITS-1:0] c2_i,
    output logic        [PIX_BITS-1:0]   c0_o,
    output logic        [PIX_BITS-1:0]   c1_o,
    output logic        [PIX_BITS-1:0]   c2_o
);

    logic signed [RECON_BITS-1:0] t, r, g, b;

    always_comb begin
        t = c0_i - (c2_i >>> 1);
        g = c2_i + t;
        b = t - (c1_i >>> 1);
        r = b + c1_i;
        if (csc_i == CSC_YCOCG) begin
            c0_o = clip_pix(r, max_point_i);
            c1_o = clip_pix(g, max_point_i);
            c2_o = clip_pix(b, max_point_i);
        end else begin
            c0_o = clip_pix(c0_i, max_point_i);
            c1_o = clip_pix(c1_i, max_point_i);
            c2_o = clip_pix(c2_i, max_point_i);
        end
    end

endmodule

// File: rtl/recon_raster_out.sv
// Converts 8x2 reconstructed blocks to RGB and streams them out in raster
// order through two ping-pong block-row banks.
module recon_raster_out
    import recon_raster_out_pkg::*;
#(
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               sos,
    input  logic [1:0]                         csc,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
    input  logic [12:0]                        maxPoint,
    input  logic                               pReconBlk_valid,
    input  logic [BLK_BITS-1:0]                pReconBlk_p,
    output logic                               pReconBlk_ready,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [WORD_BITS-1:0]               pix_data,
    output logic                               pix_sol,
    output logic                               pix_eol,
    output logic                               pix_line
);

    localparam int SWW   = $clog2(MAX_SLICE_WIDTH);
    localparam int DEPTH = 2 * (MAX_SLICE_WIDTH / 4);
    localparam int AW    = $clog2(DEPTH);
    localparam int NPIX  = BLK_H * BLK_W;

    logic clr;
    assign clr = flush | sos;

    logic [PIX_BITS-1:0] cv [NUM_COMP][NPIX];

    for (genvar i = 0; i < NPIX; i++) begin : g_px
        ycocg_to_rgb_clip u_px (
            .csc_i       (csc),
            .max_point_i (maxPoint),
            .c0_i        (pReconBlk_p[(0*NPIX+i)*RECON_BITS +: RECON_BITS]),
            .c1_i        (pReconBlk_p[(1*NPIX+i)*RECON_BITS +: RECON_BITS]),
            .c2_i        (pReconBlk_p[(2*NPIX+i)*RECON_BITS +: RECON_BITS]),
            .c0_o        (cv[0][i]),
            .c1_o        (cv[1][i]),
            .c2_o        (cv[2][i])
        );
    end

    logic [3:0][WORD_BITS-1:0] blk_w;

    always_comb begin
        blk_w = '0;
        for (int h = 0; h < 4; h++)
            for (int c = 0; c < NUM_COMP; c++)
                for (int p = 0; p < BEAT_PIX; p++)
                    blk_w[h][(c*BEAT_PIX+p)*PIX_BITS +: PIX_BITS] =
                        cv[c][(h/2)*BLK_W + (h%2)*BEAT_PIX + p];
    end

    logic [3:0][WORD_BITS-1:0] cap_q, cap_d;
    logic [2:0]                ph_q, ph_d;
    logic                      wb_q, wb_d;
    logic                      rb_q, rb_d;
    logic [1:0]                full_q, full_d;
    logic [SWW-1:0]            blk_q, blk_d;
    logic [SWW-1:0]            ridx_q, ridx_d;
    logic                      rpend_q, rpend_d;
    logic [3:0]                rside_q, rside_d;
    beat_t                     fifo_q [2];
    beat_t                     fifo_d [2];
    logic [1:0]                cnt_q, cnt_d;

    logic [SWW-1:0] qw, nw, nblk;
    assign qw   = slice_width >> 2;
    assign nw   = slice_width >> 1;
    assign nblk = slice_width >> 3;

    logic       wr_en, wr_done, last_blk, tgt_full, acc;
    logic [1:0] wh;
    logic [AW-1:0] waddr, raddr;
    word_t      wdata;

    assign wr_en    = ph_q != 3'd0;
    assign wr_done  = ph_q == 3'd4;
    assign wh       = 2'(ph_q - 3'd1);
    assign last_blk = blk_q == nblk - SWW'(1);
    assign wdata    = cap_q[wh];
    assign waddr    = AW'((wh[1] ? qw : '0) + (blk_q << 1) + SWW'(wh[0]));
    assign raddr    = AW'(ridx_q);

    // The last block of a row hands over to the other bank on its final write.
    assign tgt_full = (wr_done && last_blk) ? full_q[~wb_q] : full_q[wb_q];
    assign pReconBlk_ready = (!wr_en || wr_done) && !tgt_full && !clr;
    assign acc = pReconBlk_valid && pReconBlk_ready;

    logic       pop, rd_iss, push_slot;
    logic [2:0] occ;
    logic [3:0] side;

    assign pix_valid = cnt_q != 2'd0;
    assign pop       = pix_valid && pix_ready;
    assign occ       = {1'b0, cnt_q} - 3'(pop) + 3'(rpend_q);
    assign rd_iss    = full_q[rb_q] && (ridx_q < nw) && (occ < 3'd2) && !clr;

    assign side[3] = (ridx_q == '0) || (ridx_q == qw);
    assign side[2] = (ridx_q == qw - SWW'(1)) || (ridx_q == nw - SWW'(1));
    assign side[1] = ridx_q >= qw;
    assign side[0] = ridx_q == nw - SWW'(1);

    word_t rdata [2];
    word_t ram_q;
    assign ram_q = rb_q ? rdata[1] : rdata[0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic we, re;
        assign we = wr_en && (wb_q == 1'(b));
        assign re = rd_iss && (rb_q == 1'(b));
        sp_ram #(.DW(WORD_BITS), .DEPTH(DEPTH)) u_ram (
            .clk     (clk),
            .en_i    (we | re),
            .we_i    (we),
            .addr_i  (we ? waddr : raddr),
            .wdata_i (wdata),
            .rdata_o (rdata[b])
        );
    end

    assign push_slot = (cnt_q == 2'd2) || (cnt_q == 2'd1 && !pop);

    always_comb begin
        cap_d   = cap_q;
        ph_d    = 3'd0;
        wb_d    = wb_q;
        rb_d    = rb_q;
        full_d  = full_q;
        blk_d   = blk_q;
        ridx_d  = ridx_q;
        rpend_d = rd_iss;
        rside_d = rside_q;
        fifo_d  = fifo_q;
        cnt_d   = cnt_q - 2'(pop) + 2'(rpend_q);

        if (acc) begin
            cap_d = blk_w;
            ph_d  = 3'd1;
        end else if (wr_en && !wr_done) begin
            ph_d = ph_q + 3'd1;
        end

        if (wr_done) begin
            if (last_blk) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                blk_d        = '0;
            end else begin
                blk_d = blk_q + SWW'(1);
            end
        end

        if (rd_iss) begin
            rside_d = side;
            ridx_d  = ridx_q + SWW'(1);
        end

        if (pop) fifo_d[0] = fifo_q[1];
        if (rpend_q) fifo_d[push_slot] = {ram_q, rside_q};

        if (pop && fifo_q[0].last) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            ridx_d       = '0;
        end

        if (clr) begin
            ph_d    = 3'd0;
            wb_d    = 1'b0;
            rb_d    = 1'b0;
            full_d  = '0;
            blk_d   = '0;
            ridx_d  = '0;
            rpend_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            ph_q      <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            full_q    <= '0;
            blk_q     <= '0;
            ridx_q    <= '0;
            rpend_q   <= 1'b0;
            rside_q   <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            cnt_q     <= '0;
        end else begin
            cap_q     <= cap_d;
            ph_q      <= ph_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            full_q    <= full_d;
            blk_q     <= blk_d;
            ridx_q    <= ridx_d;
            rpend_q   <= rpend_d;
            rside_q   <= rside_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            cnt_q     <= cnt_d;
        end
    end

    assign pix_data = fifo_q[0].data;
    assign pix_sol  = pix_valid && fifo_q[0].sol;
    assign pix_eol  = pix_valid && fifo_q[0].eol;
    assign pix_line = pix_valid && fifo_q[0].line;

endmodule

// File: tb/tb_recon_raster_out.sv
// Directed bench for recon_raster_out: conversion, raster order, banking.
module tb_recon_raster_out;
    import recon_raster_out_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                sos = 1'b0;
    logic [1:0]          csc = 2'd1;
    logic [11:0]         slice_width = 12'd16;
    logic [12:0]         maxPoint = 13'd255;
    logic                blk_v = 1'b0;
    logic [BLK_BITS-1:0] blk_p = '0;
    logic                blk_rdy;
    logic                pix_valid;
    logic                pix_ready = 1'b1;
    word_t               pix_data;
    logic                pix_sol, pix_eol, pix_line;

    recon_raster_out dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .sos             (sos),
        .csc             (csc),
        .slice_width     (slice_width),
        .maxPoint        (maxPoint),
        .pReconBlk_valid (blk_v),
        .pReconBlk_p     (blk_p),
        .pReconBlk_ready (blk_rdy),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .pix_data        (pix_data),
        .pix_sol         (pix_sol),
        .pix_eol         (pix_eol),
        .pix_line        (pix_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t      d;
        logic [2:0] sb;
        int         cyc;
    } rx_t;

    rx_t   rx_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    int    stall_bad = 0;
    logic  stall_prev = 1'b0;
    word_t data_prev = '0;
    logic  rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid && pix_ready)
            rx_q.push_back('{pix_data, {pix_sol, pix_eol, pix_line}, cyc});
        if (stall_prev && pix_valid && pix_data !== data_prev)
            stall_bad++;
        stall_prev = pix_valid && !pix_ready;
        data_prev  = pix_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic word_t mkw(int c0, int c1, int c2, int step);
        word_t w;
        int    cv[3];
        w = '0;
        cv[0] = c0;
        cv[1] = c1;
        cv[2] = c2;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++)
                w[(c*4+p)*12 +: 12] = 12'(cv[c] + p * step);
        return w;
    endfunction

    function automatic logic [BLK_BITS-1:0] mk_blk(int y0, int rs, int ks,
                                                  int co, int cg);
        logic [BLK_BITS-1:0] b;
        b = '0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++) begin
                b[(r*8+k)*14 +: 14]    = 14'(y0 + r * rs + k * ks);
                b[(16+r*8+k)*14 +: 14] = 14'(co);
                b[(32+r*8+k)*14 +: 14] = 14'(cg);
            end
        return b;
    endfunction

    function automatic logic [2:0] sbx(int j, int qw);
        logic sol, eol, line;
        sol  = (j == 0) || (j == qw);
        eol  = (j == qw - 1) || (j == 2 * qw - 1);
        line = j >= qw;
        return {sol, eol, line};
    endfunction

    function automatic word_t rxd(int i);
        if (i < rx_q.size()) return rx_q[i].d;
        return '1;
    endfunction

    function automatic logic [2:0] rxs(int i);
        if (i < rx_q.size()) return rx_q[i].sb;
        return 3'b111;
    endfunction

    function automatic int rxc(int i);
        if (i < rx_q.size()) return rx_q[i].cyc;
        return -1000;
    endfunction

    task automatic pulse_sos();
        sos = 1'b1;
        @(posedge clk);
        #1 sos = 1'b0;
        rx_q.delete();
    endtask

    task automatic send_blk(input logic [BLK_BITS-1:0] p, output int nrx);
        int t;
        t = 0;
        blk_p = p;
        blk_v = 1'b1;
        @(negedge clk);
        while (!blk_rdy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        nrx = rx_q.size();
        if (!blk_rdy) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 blk_v = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() < n) check(tag, rx_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic one_blk(input string tag, input logic [BLK_BITS-1:0] b,
                           input word_t e);
        int nrx;
        pulse_sos();
        send_blk(b, nrx);
        wait_rx(4, {tag, "_wait"});
        check({tag, "_b0"}, rxd(0), e);
        check({tag, "_b3"}, rxd(3), e);
    endtask

    initial begin
        int    nrx, bad, seen, t, v0;
        word_t ew;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", blk_rdy, 1);
        check("rst_valid", pix_valid, 0);
        check("rst_sol", pix_sol, 0);
        check("rst_eol", pix_eol, 0);
        check("rst_line", pix_line, 0);
        @(posedge clk);
        #1;

        // Two uniform blocks, one block-row, continuous output.
        slice_width = 12'd16;
        maxPoint    = 13'd255;
        csc         = 2'd1;
        pix_ready   = 1'b1;
        pulse_sos();
        send_blk(mk_blk(100, 0, 0, 20, 10), nrx);
        send_blk(mk_blk(100, 0, 0, 20, 10), nrx);
        wait_rx(8, "t1_wait");
        ew = mkw(105, 105, 85, 0);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t1_data%0d", j), rxd(j), ew);
            check($sformatf("t1_sb%0d", j), rxs(j), sbx(j, 4));
        end
        check("t1_burst", rxc(7) - rxc(0), 7);

        // Clipping and pass-through cases on an 8-wide slice.
        slice_width = 12'd8;
        one_blk("clip_hi", mk_blk(300, 0, 0, 0, 0), mkw(255, 255, 255, 0));
        check("sw8_sb1", rxs(1), 3'b010);
        check("sw8_sb2", rxs(2), 3'b101);
        one_blk("clip_neg", mk_blk(-5, 0, 0, 0, 0), mkw(0, 0, 0, 0));
        maxPoint = 13'd1023;
        one_blk("mp1023", mk_blk(1000, 0, 0, 0, 0), mkw(1000, 1000, 1000, 0));
        maxPoint = 13'd255;
        one_blk("ycocg_neg", mk_blk(100, 0, 0, -41, 31), mkw(65, 116, 106, 0));
        csc = 2'd0;
        one_blk("rgb_pass", mk_blk(300, 0, 0, 50, -1), mkw(255, 50, 0, 0));
        csc = 2'd1;

        // Raster order: pixel value encodes line, block and column.
        slice_width = 12'd16;
        pulse_sos();
        send_blk(mk_blk(0, 64, 1, 0, 0), nrx);
        send_blk(mk_blk(8, 64, 1, 0, 0), nrx);
        wait_rx(8, "ras_wait");
        for (int j = 0; j < 8; j++) begin
            v0 = (j / 4) * 64 + ((j % 4) / 2) * 8 + (j % 2) * 4;
            check($sformatf("ras_beat%0d", j), rxd(j), mkw(v0, v0, v0, 1));
        end

        // Backpressure: both banks fill, the third block must wait.
        slice_width = 12'd8;
        pix_ready   = 1'b0;
        pulse_sos();
        send_blk(mk_blk(10, 0, 0, 0, 0), nrx);
        send_blk(mk_blk(20, 0, 0, 0, 0), nrx);
        blk_p = mk_blk(30, 0, 0, 0, 0);
        blk_v = 1'b1;
        seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (blk_rdy) seen++;
        end
        check("bp_blocked", seen, 0);
        @(posedge clk);
        #1 pix_ready = 1'b1;
        send_blk(mk_blk(30, 0, 0, 0, 0), nrx);
        check("bp_beats_at_accept", nrx, 4);
        wait_rx(12, "bp_wait");
        check("bp_count", rx_q.size(), 12);
        check("bp_bank0", rxd(0), mkw(10, 10, 10, 0));
        check("bp_bank1", rxd(4), mkw(20, 20, 20, 0));
        check("bp_block2", rxd(8), mkw(30, 30, 30, 0));

        // Random downstream stalls over 20 block-rows.
        slice_width = 12'd16;
        pulse_sos();
        fork
            begin
                for (int n = 0; n < 40; n++)
                    send_blk(mk_blk(((n / 2) * 5) % 128 + (n % 2) * 8,
                                    16, 1, 0, 0), nrx);
                wait_rx(160, "rnd_wait");
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 pix_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        pix_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            v0 = ((i / 8) * 5) % 128 + (((i % 8) % 4) / 2) * 8
               + ((i % 8) / 4) * 16 + (i % 2) * 4;
            if (rxd(i) !== mkw(v0, v0, v0, 1)) bad++;
            if (rxs(i) !== sbx(i % 8, 4)) bad++;
        end
        check("rnd_count", rx_q.size(), 160);
        check("rnd_data", bad, 0);
        check("stall_stable", stall_bad, 0);

        // Flush in the middle of a block-row, then a clean row.
        pix_ready = 1'b0;
        pulse_sos();
        send_blk(mk_blk(50, 0, 0, 0, 0), nrx);
        send_blk(mk_blk(50, 0, 0, 0, 0), nrx);
        repeat (3) begin
            t = 0;
            @(negedge clk);
            while (!pix_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1 pix_ready = 1'b1;
            @(posedge clk);
            #1 pix_ready = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        check("fl_pre_valid", pix_valid, 1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_valid", pix_valid, 0);
        check("fl_ready", blk_rdy, 1);
        check("fl_beats", rx_q.size(), 3);
        @(posedge clk);
        #1;
        rx_q.delete();
        pix_ready = 1'b1;
        send_blk(mk_blk(100, 64, 1, 0, 0), nrx);
        send_blk(mk_blk(108, 64, 1, 0, 0), nrx);
        wait_rx(8, "fl_row_wait");
        check("fl_row_b0", rxd(0), mkw(100, 100, 100, 1));
        check("fl_row_sb0", rxs(0), 3'b100);
        check("fl_row_b5", rxd(5), mkw(168, 168, 168, 1));
        check("fl_row_sb7", rxs(7), 3'b011);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/recon_raster_out.md
Name: recon_raster_out

Overview:
- Output-side consumer of reconstructed blocks in the VDC-M decoder. It accepts 8x2 reconstructed blocks (pReconBlk, 3 components, 14-bit signed) and applies the inverse colour transform with clipping to [0, maxPoint].
- It reorders blocks into raster order: 4-pixel beats, line 0 then line 1 of each block-row.
- Two ping-pong block-row banks let the next block-row be written while the previous one streams out under valid/ready backpressure.

Parameters:
MAX_SLICE_WIDTH, 2560, maximum slice width in pixels; sets bank depth of 2*(MAX_SLICE_WIDTH/4) words of 144 bits.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of all state and any in-flight data
sos  input  1  start of slice; same effect as flush; slice_width/csc/maxPoint sampled from here on
csc  input  2  0 RGB, 1 YCoCg, 2 YCbCr
slice_width  input  $clog2(MAX_SLICE_WIDTH)  pixels, multiple of 8, >=8
maxPoint  input  13  255, 1023 or 4095
pReconBlk_valid  input  1  block available
pReconBlk_p  input  2*8*3*14  sample (comp c, row r, col k) at [(c*16+r*8+k)*14+:14]
pReconBlk_ready  output  1  block accepted when valid&ready
pix_valid  output  1  output beat available
pix_ready  input  1  downstream accepts beat
pix_data  output  4*3*12  comp c, pixel p (p=0 leftmost) at [(c*4+p)*12+:12]
pix_sol  output  1  beat is first of a line
pix_eol  output  1  beat is last of a line
pix_line  output  1  0 = upper line of block-row, 1 = lower

Behaviour:
- Reset values:
  - pReconBlk_ready=1, pix_valid=0, pix_sol/pix_eol/pix_line=0.
  - Bank-full flags cleared; write bank and read bank = 0; all counters 0.
- Inverse CSC (combinational, before capture), csc==1:
  - t = Y-(Cg>>>1); G = Cg+t; B = t-(Co>>>1); R = B+Co; all 14-bit signed.
  - Each result is clipped: negative -> 0; >maxPoint -> maxPoint; else low 12 bits.
  - csc!=1: components pass through with the same clipping.
- Write path:
  - On accept at cycle T, the converted block is captured in a register.
  - Writes occur at T+1..T+4 into the write bank, in order: row0 cols0-3, row0 cols4-7, row1 cols0-3, row1 cols4-7.
  - Word address = line*(slice_width/4) + blk_idx*2 + half.
  - pReconBlk_ready=0 during T+1..T+3. It returns high at T+4 unless the next write bank is full.
- Bank full:
  - The last block of a row (blk_idx = slice_width/8-1) sets full[wb] at its T+4 write.
  - At the same time wb toggles and blk_idx resets to 0.
  - If full[new wb]=1, ready stays 0 until it clears.
- Read path:
  - When full[rb]=1, the bank is read sequentially from word 0 to 2*(slice_width/4)-1.
  - The RAM has 1-cycle read latency and feeds a 2-entry output FIFO.
  - A read is issued only if FIFO occupancy plus the outstanding read is <2. This gives 1 beat/cycle with pix_ready held high.
- Sideband:
  - pix_sol on word index 0 and slice_width/4.
  - pix_eol on slice_width/4-1 and 2*slice_width/4-1.
  - pix_line = word index >= slice_width/4.
- Bank release:
  - On acceptance (pix_valid&pix_ready) of the final beat, full[rb] clears and rb toggles.
  - Write-side ready may rise the next cycle.
- Latency: full[rb] set at cycle S -> first pix_valid at S+2.
- Simultaneous events:
  - Set of full[wb] and clear of full[rb] in the same cycle address different banks; both take effect.
  - flush/sos has priority over everything.
- flush/sos mid-operation:
  - Clears flags, counters and FIFO, and drops the captured block.
  - pix_valid drops the next cycle and ready returns to 1.
- Bank RAMs: single-port, one per bank. Writer and reader never address the same bank in a cycle.
- pix_data must remain stable while pix_valid=1 and pix_ready=0.

Decomposition:
- Shared package:
  - Constants BLK_W=8, BLK_H=2, NUM_COMP=3, RECON_BITS=14, PIX_BITS=12, BEAT_PIX=4.
  - CSC code constants CSC_RGB/YCOCG/YCBCR.
- Sub-modules:
  - ycocg_to_rgb_clip: combinational per-pixel inverse CSC plus clip, instantiated 16x.
  - Existing sp_ram: instantiated twice, for the banks.

Test Plan:
- slice_width=16, maxPoint=255, csc=1, two blocks, all Y=100/Co=20/Cg=10 -> 8 beats every cycle, each pixel R=105,G=105,B=85. sol on beats 0 and 4, eol on beats 3 and 7, pix_line=1 on beats 4-7.
- csc=1, maxPoint=255, Y=300,Co=0,Cg=0 -> RGB 255. Y=-5 -> 0. maxPoint=1023, Y=1000 -> 1000.
- Raster order: blocks with col index encoded in Y (Co=Cg=0), slice_width=16 -> line0 beat2 pixels = block1 row0 cols0-3.
- pix_ready=0 throughout, slice_width=8:
  - blocks 0 and 1 are accepted;
  - block 2 sees ready=0;
  - raise pix_ready -> 4 beats from bank0, then block 2 is accepted.
- Random pix_ready toggling at 50% -> pix_data stable while stalled, no beat lost or duplicated over 20 block-rows.
- flush asserted after 3 of 8 output beats -> pix_valid=0 next cycle, ready=1; a new block-row streams from word 0 correctly.
